// File: rtl/neurex_pkg.sv
// Shared types and defaults for the systolic row feeder.
// Holds the feeder state encoding, default geometry and a lane slice helper.
package neurex_pkg;

  localparam int DEF_SYS_ROW    = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } feeder_state_e;

  // Lane 0 sits in the LSBs of a packed activation word.
  function automatic logic [DEF_DATA_WIDTH-1:0] lane_slice(
    input logic [DEF_SYS_ROW*DEF_DATA_WIDTH-1:0] word,
    input int                                    lane
  );
    return word[lane*DEF_DATA_WIDTH +: DEF_DATA_WIDTH];
  endfunction

endpackage

// File: rtl/sys_row_skew_feeder_if.sv
// Row feeder bus: word write stream and command in, skewed per-row lanes and status out.
// The master side drives words and commands; the slave side is the feeder itself.
interface sys_row_skew_feeder_if
  import neurex_pkg::*;
#(
  parameter int SYS_ROW    = DEF_SYS_ROW,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                          in_en;
  logic [SYS_ROW*DATA_WIDTH-1:0] in_data;
  logic                          in_ready;
  logic                          start;
  logic [DATA_WIDTH-1:0]         num_vec;
  logic [SYS_ROW-1:0]            out_valid;
  logic [SYS_ROW*DATA_WIDTH-1:0] out_data;
  logic                          busy;
  logic                          done;
  logic                          overflow;

  modport master (
    output in_en, in_data, start, num_vec,
    input  in_ready, out_valid, out_data, busy, done, overflow
  );

  modport slave (
    input  in_en, in_data, start, num_vec,
    output in_ready, out_valid, out_data, busy, done, overflow
  );

endinterface

// File: rtl/neurex_word_fifo.sv
// Single-clock word FIFO, no fall-through: a word pushed at one edge is the head from the next.
// Push is dropped when full and pop is ignored when empty; the caller flags overflow.
module neurex_word_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/sys_row_skew_feeder.sv
// Streams buffered activation words into the array edge with lane r delayed r cycles.
// Writes are accepted in every state (dropped and flagged when full); start outside IDLE is ignored.
module sys_row_skew_feeder
  import neurex_pkg::*;
#(
  parameter int SYS_ROW    = DEF_SYS_ROW,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  sys_row_skew_feeder_if.slave  bus
);

  localparam int WW  = SYS_ROW * DATA_WIDTH;
  localparam int FCW = (SYS_ROW > 2) ? $clog2(SYS_ROW - 1) : 1;
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'((SYS_ROW >= 2) ? (SYS_ROW - 2) : 0);

  feeder_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] num_q, num_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] cnt_inc;
  logic [FCW-1:0]        flush_q, flush_d;
  logic                  overflow_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [WW-1:0]         fifo_head;
  logic                  pop;
  logic                  busy;
  logic                  done;

  neurex_word_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (bus.in_en),
    .wdata_i (bus.in_data),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cnt_inc = cnt_q + DATA_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    pop     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_vec != '0) begin
            state_d = STREAM;
            num_d   = bus.num_vec;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      STREAM: begin
        busy = 1'b1;
        if (!fifo_empty) begin
          pop   = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == num_q) begin
            // A single-row array has no skew left to drain.
            state_d = (SYS_ROW > 1) ? FLUSH : DONE;
            flush_d = '0;
          end
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (flush_q == FLUSH_LAST) begin
          state_d = DONE;
        end else begin
          flush_d = flush_q + FCW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      num_q      <= '0;
      cnt_q      <= '0;
      flush_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      if (bus.in_en && fifo_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Lane r owns an (r+1)-deep chain; element 0 is loaded by the pop, bubbles carry zero data.
  for (genvar r = 0; r < SYS_ROW; r++) begin : g_lane
    logic [r:0]            vld_q;
    logic [DATA_WIDTH-1:0] dat_q [r+1];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld_q <= '0;
        for (int k = 0; k <= r; k++) begin
          dat_q[k] <= '0;
        end
      end else begin
        vld_q[0] <= pop;
        dat_q[0] <= pop ? fifo_head[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= r; k++) begin
          vld_q[k] <= vld_q[k-1];
          dat_q[k] <= dat_q[k-1];
        end
      end
    end

    assign bus.out_valid[r]                          = vld_q[r];
    assign bus.out_data[r*DATA_WIDTH +: DATA_WIDTH] = dat_q[r];
  end

  assign bus.in_ready = !fifo_full;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.overflow = overflow_q;

endmodule
